// File: rtl/twi_pkg.sv
// twi_pkg: shared framing state encoding and bus constants for the TWI monitor.
package twi_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK} state_t;
  localparam int BITS_PER_BYTE = 8;
  localparam logic ACK = 1'b0;
endpackage

// File: rtl/twi_line_conditioner.sv
// twi_line_conditioner: synchronizes one raw bus pin, rejects short glitches,
// and keeps the previous filtered value for edge detection.
module twi_line_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin,
  output logic o_filt,
  output logic o_prev
);
  localparam int CW = FILTER_LEN > 1 ? $clog2(FILTER_LEN) : 1;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0] r_cnt;
  logic r_filt, r_prev;
  logic w_s;
  assign w_s    = r_sync[SYNC_STAGES-1];
  assign o_filt = r_filt;
  assign o_prev = r_prev;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync <= '1;
      r_cnt  <= '0;
      r_filt <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_prev <= r_filt;
      // the filtered line flips on the FILTER_LEN-th consecutive differing sample
      if (w_s == r_filt) r_cnt <= '0;
      else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_filt <= w_s;
        r_cnt  <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/twi_frame_monitor.sv
// twi_frame_monitor: passive TWI framing monitor; detects START/STOP, strobes
// each data bit and reports every tagged byte with its acknowledge bit.
module twi_frame_monitor
  import twi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       shift_en,
  output logic       shift_bit,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_addr,
  output logic       byte_ack_n,
  output logic       rw,
  output logic       start_seen,
  output logic       stop_seen,
  output logic       bus_busy,
  output logic       frame_error
);
  logic w_scl, w_scl_p, w_sda, w_sda_p;
  logic w_rise, w_start, w_stop, w_mid, w_bit_st, w_ack_st;
  state_t r_state;
  logic [3:0] r_cnt;
  logic [7:0] r_shift;

  twi_line_conditioner #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl (
    .clk(clk), .reset_n(reset_n), .i_pin(scl_in), .o_filt(w_scl), .o_prev(w_scl_p));
  twi_line_conditioner #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda (
    .clk(clk), .reset_n(reset_n), .i_pin(sda_in), .o_filt(w_sda), .o_prev(w_sda_p));

  assign w_rise   = w_scl & ~w_scl_p;
  assign w_start  = w_scl & w_scl_p & w_sda_p & ~w_sda;
  assign w_stop   = w_scl & w_scl_p & ~w_sda_p & w_sda;
  assign w_mid    = r_cnt != 4'd0;
  assign w_bit_st = r_state == ADDR || r_state == DATA;
  assign w_ack_st = r_state == ADDR_ACK || r_state == DATA_ACK;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      shift_en     <= 1'b0;
      shift_bit    <= 1'b0;
      byte_valid   <= 1'b0;
      byte_data    <= '0;
      byte_is_addr <= 1'b0;
      byte_ack_n   <= 1'b0;
      rw           <= 1'b0;
      start_seen   <= 1'b0;
      stop_seen    <= 1'b0;
      bus_busy     <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      start_seen  <= w_start;
      stop_seen   <= w_stop;
      frame_error <= (w_start | w_stop) & w_mid;
      shift_en    <= 1'b0;
      byte_valid  <= 1'b0;
      if (w_start | w_stop) begin
        r_cnt    <= '0;
        bus_busy <= w_start;
        r_state  <= w_start ? ADDR : IDLE;
      end else if (w_rise && w_bit_st) begin
        shift_en  <= 1'b1;
        shift_bit <= w_sda;
        r_shift   <= {r_shift[6:0], w_sda};
        r_cnt     <= r_cnt + 4'd1;
        if (r_cnt == 4'(BITS_PER_BYTE - 1)) r_state <= r_state == ADDR ? ADDR_ACK : DATA_ACK;
      end else if (w_rise && w_ack_st) begin
        // a NACK still continues into data: the monitor never steers the bus
        byte_valid   <= 1'b1;
        byte_data    <= r_shift;
        byte_is_addr <= r_state == ADDR_ACK;
        byte_ack_n   <= w_sda != ACK;
        if (r_state == ADDR_ACK) rw <= r_shift[0];
        r_cnt   <= '0;
        r_state <= DATA;
      end
    end
  end
endmodule

// File: doc/twi_frame_monitor.md
Name: twi_frame_monitor

Overview:
Passive TWI (I2C) bus framing controller. Conditions the raw SCL/SDA pins, detects START/STOP, and sequences bit capture, one strobe per data bit. Assembles each 8-bit byte plus its ACK bit and tags it as address or data. Drives the monitor's byte datapath: shift_en/shift_bit feed an external deserializer, and byte_* carries the complete tagged byte.

Parameters:
SYNC_STAGES, 2, synchronizer flops per pin (min 2)
FILTER_LEN, 3, consecutive equal synchronized samples required before the filtered line changes (min 1)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
scl_in  in  1  raw SCL pin, asynchronous
sda_in  in  1  raw SDA pin, asynchronous
shift_en  out  1  one-cycle strobe per data bit (bits 1..8 of a byte; never for the ACK bit)
shift_bit  out  1  sampled SDA value, valid with shift_en
byte_valid  out  1  one-cycle strobe after the ACK bit of each byte
byte_data  out  8  captured byte, MSB first on the wire; held until the next byte_valid
byte_is_addr  out  1  byte_data is the first byte after START/repeated START; held
byte_ack_n  out  1  sampled ACK bit (0 = ACK, 1 = NACK); held
rw  out  1  LSB of the most recent address byte; held
start_seen  out  1  one-cycle strobe on START or repeated START
stop_seen  out  1  one-cycle strobe on STOP
bus_busy  out  1  high from START until STOP
frame_error  out  1  one-cycle strobe on a START/STOP that truncates a byte

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low.
- Reset values: all outputs 0. State is IDLE and bit counter is 0. Synchronizer, filter and previous-value registers preset to 1 (idle bus), so no edge is reported after reset release.
- Line conditioning, per pin: SYNC_STAGES-flop synchronizer, then the filter. The filtered value takes the synchronized value once that value has differed from it for FILTER_LEN consecutive cycles. Shorter glitches are discarded.
- Event detection is on filtered values f_scl/f_sda and their previous-cycle copies:
  - SCL rise: f_scl 0->1.
  - START: f_sda 1->0 while f_scl is 1 in both cycles.
  - STOP: f_sda 0->1 while f_scl is 1 in both cycles.
  - If SCL and SDA change in the same cycle, there is no START/STOP. An SCL rise samples the new f_sda.
- Latency: every output strobe is registered. It appears exactly SYNC_STAGES+FILTER_LEN+1 cycles after the raw pin edge that causes it.
- States:
  - IDLE: SCL rises are ignored. START -> ADDR.
  - ADDR, DATA: each SCL rise pulses shift_en with shift_bit=f_sda, shifts into the internal byte, and increments the bit count. The 8th rise moves to the ACK state (ADDR_ACK or DATA_ACK).
  - ADDR_ACK, DATA_ACK: the SCL rise samples ACK and pulses byte_valid with the updated byte_data, byte_is_addr (1 in ADDR_ACK) and byte_ack_n. ADDR_ACK also loads rw = byte bit 0. Bit count clears, then -> DATA. A NACK still -> DATA; the monitor is passive.
- START in any state: start_seen=1, bus_busy=1, bit count 0, -> ADDR. If the bit count was 1..8 (mid-byte), frame_error=1 and no byte_valid is issued.
- STOP in any non-IDLE state: stop_seen=1, bus_busy=0, -> IDLE. Same mid-byte rule gives frame_error=1.
- STOP in IDLE: stop_seen=1, no error.
- Strobe exclusivity: byte_valid and frame_error never assert in the same cycle. start_seen and stop_seen are mutually exclusive.
- Counter width is 4 bits and never exceeds 8. No wrap is possible.
- reset_n low mid-byte: immediate return to reset values and the partial byte is discarded. After release, SCL activity is ignored until a START.

Decomposition:
- Package twi_pkg: state enum (IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK), BITS_PER_BYTE=8, constant ACK=1'b0.
- Sub-module twi_line_conditioner: synchronizer + glitch filter + previous-value register, parameterised by SYNC_STAGES/FILTER_LEN. Instantiated once for SCL and once for SDA.

Test Plan:
- START, bits 1010_0000, ACK=0 -> start_seen once; 8 shift_en with bits 1,0,1,0,0,0,0,0; byte_valid with byte_data=0xA0, byte_is_addr=1, byte_ack_n=0, rw=0; bus_busy=1.
- Continue with data 0x3C, NACK, then STOP -> byte_valid with 0x3C, byte_is_addr=0, byte_ack_n=1; then stop_seen, bus_busy=0, frame_error never set.
- After the first data ACK, repeated START and address 0xA1 -> start_seen, byte_valid with 0xA1, byte_is_addr=1, rw=1, no frame_error.
- START, address 0xA0 ACK, 4 data bits, then STOP -> 4 shift_en, frame_error=1 and stop_seen in the same cycle, no second byte_valid, state IDLE.
- SCL low pulses of FILTER_LEN-1 cycles during DATA -> no shift_en. A FILTER_LEN-cycle pulse -> exactly one shift_en, at latency SYNC_STAGES+FILTER_LEN+1.
- reset_n low for 1 cycle after 5 data bits, then 9 SCL pulses without START -> all outputs 0, no shift_en, no byte_valid.
